fifo_rd_fwft: RTL

Read-side adapter for the async FIFO. It sits directly downstream of the read-pointer/empty logic and the registered FIFO memory in the read clock domain. It turns the standard-read interface (rd_en in, data one cycle later) into a first-word-fall-through AXI-Stream master. A 2-entry output buffer sustains one beat per cycle under full throughput and absorbs backpressure without losing in-flight reads.

---
 rtl/fifo_rd_fwft.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_rd_fwft.sv
// rtl/fifo_rd_fwft.sv - FIFO standard-read to first-word-fall-through stream adapter with 2-entry buffer.
// Optional beat/stall counters under macro FIFO_RD_FWFT_STATS_EN.
module fifo_rd_fwft #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  rd_clk_i,
    input  logic                  rd_rstn_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  rd_en_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic [1:0]            occupancy_o
`ifdef FIFO_RD_FWFT_STATS_EN
    ,
    output logic [31:0]           beat_cnt_o,
    output logic [31:0]           stall_cnt_o
`endif
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    logic       pop;
    logic       push;
    logic [2:0] load;

    assign pop  = tvalid_q & m_tready_i;
    assign load = {1'b0, occ_q} + {2'b00, inflight_q};
    // A pop this cycle frees a slot, so a full buffer can still issue a read.
    assign rd_en_o = rd_rstn_i & ~empty_i & ~flush_i & ((load < 3'd2) | pop);
    assign push    = inflight_q & ~flush_i;

    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        skid_d     = skid_q;
        inflight_d = rd_en_o;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        occ_d  = 2'd1;
                        head_d = rd_data_i;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = rd_data_i;
                    end else if (push) begin
                        occ_d  = 2'd2;
                        skid_d = rd_data_i;
                    end else if (pop) begin
                        occ_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        occ_d  = 2'd1;
                        head_d = skid_q;
                    end
                end
                default: occ_d = 2'd0;
            endcase
        end
        tvalid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge rd_clk_i or negedge rd_rstn_i) begin
        if (!rd_rstn_i) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            tvalid_q   <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            tvalid_q   <= tvalid_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    always_ff @(posedge rd_clk_i) begin
        if (rd_rstn_i) begin
            assert (!(push && (occ_q == 2'd2)));
        end
    end

    assign m_tdata_o   = head_q;
    assign m_tvalid_o  = tvalid_q;
    assign occupancy_o = occ_q;

`ifdef FIFO_RD_FWFT_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        beat_cnt_d  = beat_cnt_q + {31'd0, pop};
        stall_cnt_d = stall_cnt_q + {31'd0, tvalid_q & ~m_tready_i};
    end

    always_ff @(posedge rd_clk_i or negedge rd_rstn_i) begin
        if (!rd_rstn_i) begin
            beat_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_cnt_o  = beat_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
